// File: rtl/xor_share_arbiter.sv
// -----------------------------------------------------------------------------
// xor_share_arbiter
//
// One registered XOR unit (y = a ^ b) shared between NREQ requesters through
// round-robin arbitration. The winning requester's operand pair is XORed into
// a single output register and tagged with the requester index.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  [NREQ]        requester i presents an operand pair
//   req_ready  [NREQ]        requester i accepted this cycle (one-hot or zero)
//   req_a      [NREQ*WIDTH]  operand a, requester i at [i*WIDTH +: WIDTH]
//   req_b      [NREQ*WIDTH]  operand b, same packing
//   out_valid                out_y/out_id hold a result
//   out_ready                consumer accepts the result
//   out_y      [WIDTH]       registered a ^ b of the granted pair
//   out_id     [ID_W]        requester that produced out_y
//   done_cnt   [CNT_W]       results accepted downstream, wrapping
// -----------------------------------------------------------------------------
module xor_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_y,
    output logic [ID_W-1:0]       out_id,
    output logic [CNT_W-1:0]      done_cnt
);

    logic                 out_valid_q;
    logic [WIDTH-1:0]     out_y_q;
    logic [ID_W-1:0]      out_id_q;
    logic [CNT_W-1:0]     done_cnt_q;
    logic [ID_W-1:0]      last_grant_q;

    logic                 load;
    logic                 drain;
    logic [NREQ-1:0]      grant_oh;
    logic [ID_W-1:0]      grant_idx;
    logic                 grant_found;
    logic [ID_W:0]        scan_idx;
    logic [WIDTH-1:0]     out_y_d;

    logic [WIDTH-1:0]     xor_arr [NREQ];

    // Per-requester XOR of the operand pair; the mux after it picks the winner.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_xor
            assign xor_arr[gi] = req_a[gi*WIDTH +: WIDTH] ^ req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // The output register can take a new result when empty or being drained.
    assign load  = !out_valid_q || out_ready;
    assign drain = out_valid_q && out_ready;

    // Round-robin scan starting one past the last granted requester. scan_idx
    // carries one extra bit so last_grant + k never overflows before wrapping.
    always_comb begin
        grant_oh    = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        scan_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = {1'b0, last_grant_q} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(NREQ)) begin
                scan_idx = scan_idx - (ID_W+1)'(NREQ);
            end
            if (!grant_found && req_valid[scan_idx[ID_W-1:0]]) begin
                grant_found                   = 1'b1;
                grant_idx                     = scan_idx[ID_W-1:0];
                grant_oh[scan_idx[ID_W-1:0]]  = 1'b1;
            end
        end
        // No acceptance while the result is stalled or while held in reset.
        if (!load || !rst_n) begin
            grant_oh    = '0;
            grant_found = 1'b0;
        end
    end

    assign out_y_d   = xor_arr[grant_idx];
    assign req_ready = grant_oh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_y_q      <= '0;
            out_id_q     <= '0;
            done_cnt_q   <= '0;
            last_grant_q <= ID_W'(NREQ-1);
        end else begin
            if (grant_found) begin
                // Loading over a draining result keeps out_valid high: no bubble.
                out_valid_q  <= 1'b1;
                out_y_q      <= out_y_d;
                out_id_q     <= grant_idx;
                last_grant_q <= grant_idx;
            end else if (drain) begin
                out_valid_q  <= 1'b0;
            end
            if (drain) begin
                done_cnt_q <= done_cnt_q + 1'b1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_id    = out_id_q;
    assign done_cnt  = done_cnt_q;

endmodule
